// File: rtl/ps2_letter_decoder.sv
// ps2_letter_decoder
//   Receives raw PS/2 keyboard frames, validates start/parity/stop bits and
//   inter-edge timing, tracks make/break/extended prefixes, and turns letter
//   make codes into an ASCII byte with a one-cycle letter_valid pulse. The
//   Enter make code produces a separate one-cycle enter_pressed pulse.
//
// Ports
//   CLOCK_50      in   system clock, all flops on its rising edge
//   resetn        in   asynchronous active-low reset
//   PS2_CLK       in   keyboard clock (asynchronous)
//   PS2_DAT       in   keyboard data (asynchronous)
//   ascii_out     out  ASCII of last accepted letter (0x41-0x5A), held
//   letter_valid  out  one-cycle pulse when a new letter is accepted
//   enter_pressed out  one-cycle pulse on an Enter make code
//   frame_error   out  one-cycle pulse on bad start/parity/stop or timeout
module ps2_letter_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] ascii_out,
  output logic       letter_valid,
  output logic       enter_pressed,
  output logic       frame_error
);

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_state_t;
  typedef enum logic [1:0] {C_NORMAL, C_BREAK, C_EXT, C_EXT_BREAK} code_state_t;

  // Returns {hit, ascii}; hit is 0 for any scan code that is not a letter.
  function automatic logic [8:0] letter_lookup(input logic [7:0] code);
    case (code)
      8'h1C: letter_lookup = {1'b1, 8'h41};  // A
      8'h32: letter_lookup = {1'b1, 8'h42};  // B
      8'h21: letter_lookup = {1'b1, 8'h43};  // C
      8'h23: letter_lookup = {1'b1, 8'h44};  // D
      8'h24: letter_lookup = {1'b1, 8'h45};  // E
      8'h2B: letter_lookup = {1'b1, 8'h46};  // F
      8'h34: letter_lookup = {1'b1, 8'h47};  // G
      8'h33: letter_lookup = {1'b1, 8'h48};  // H
      8'h43: letter_lookup = {1'b1, 8'h49};  // I
      8'h3B: letter_lookup = {1'b1, 8'h4A};  // J
      8'h42: letter_lookup = {1'b1, 8'h4B};  // K
      8'h4B: letter_lookup = {1'b1, 8'h4C};  // L
      8'h3A: letter_lookup = {1'b1, 8'h4D};  // M
      8'h31: letter_lookup = {1'b1, 8'h4E};  // N
      8'h44: letter_lookup = {1'b1, 8'h4F};  // O
      8'h4D: letter_lookup = {1'b1, 8'h50};  // P
      8'h15: letter_lookup = {1'b1, 8'h51};  // Q
      8'h2D: letter_lookup = {1'b1, 8'h52};  // R
      8'h1B: letter_lookup = {1'b1, 8'h53};  // S
      8'h2C: letter_lookup = {1'b1, 8'h54};  // T
      8'h3C: letter_lookup = {1'b1, 8'h55};  // U
      8'h2A: letter_lookup = {1'b1, 8'h56};  // V
      8'h1D: letter_lookup = {1'b1, 8'h57};  // W
      8'h22: letter_lookup = {1'b1, 8'h58};  // X
      8'h35: letter_lookup = {1'b1, 8'h59};  // Y
      8'h1A: letter_lookup = {1'b1, 8'h5A};  // Z
      default: letter_lookup = 9'h000;
    endcase
  endfunction

  logic         clk_s1, clk_s2, clk_prev;
  logic         dat_s1, dat_s2;
  logic         fall;
  frame_state_t frame_state;
  logic [2:0]   bit_cnt;
  logic [7:0]   shift_byte;
  logic         parity_ok;
  logic [15:0]  idle_cnt;
  logic         byte_rdy;
  code_state_t  code_state;
  logic [7:0]   held_code;
  logic [8:0]   lookup;

  // Two-flop synchronisers plus one history flop for the clock edge detect.
  // Reset to 1 so an idle (high) bus never looks like a falling edge.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= PS2_CLK;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= PS2_DAT;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // Frame receiver. An edge always takes priority over the timeout, so a
  // frame that finishes exactly on the limit is still accepted.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      frame_state <= F_IDLE;
      bit_cnt     <= 3'd0;
      shift_byte  <= 8'h00;
      parity_ok   <= 1'b0;
      idle_cnt    <= 16'd0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      if (fall) begin
        idle_cnt <= 16'd0;
        case (frame_state)
          F_IDLE: begin
            if (!dat_s2) begin
              frame_state <= F_DATA;
              bit_cnt     <= 3'd0;
            end else begin
              frame_error <= 1'b1;
            end
          end
          F_DATA: begin
            shift_byte <= {dat_s2, shift_byte[7:1]};  // LSB arrives first
            bit_cnt    <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) frame_state <= F_PARITY;
          end
          F_PARITY: begin
            parity_ok   <= ^{shift_byte, dat_s2};     // odd parity over 9 bits
            frame_state <= F_STOP;
          end
          F_STOP: begin
            if (!(dat_s2 && parity_ok)) frame_error <= 1'b1;
            frame_state <= F_IDLE;
          end
          default: frame_state <= F_IDLE;
        endcase
      end else if (frame_state == F_IDLE) begin
        idle_cnt <= 16'd0;
      end else if (idle_cnt == TIMEOUT_LIM) begin
        frame_state <= F_IDLE;
        frame_error <= 1'b1;
        idle_cnt    <= 16'd0;
      end else begin
        idle_cnt <= idle_cnt + 16'd1;
      end
    end
  end

  // Complete, valid byte is available during the stop-bit edge cycle.
  assign byte_rdy = (frame_state == F_STOP) && fall && dat_s2 && parity_ok;
  assign lookup   = letter_lookup(shift_byte);

  // Scan-code handler: prefix tracking and make-code decoding.
  // held_code suppresses typematic repeats until its break code arrives.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      code_state    <= C_NORMAL;
      held_code     <= 8'h00;
      ascii_out     <= 8'h00;
      letter_valid  <= 1'b0;
      enter_pressed <= 1'b0;
    end else begin
      letter_valid  <= 1'b0;
      enter_pressed <= 1'b0;
      if (byte_rdy) begin
        case (code_state)
          C_NORMAL: begin
            if (shift_byte == 8'hF0) begin
              code_state <= C_BREAK;
            end else if (shift_byte == 8'hE0) begin
              code_state <= C_EXT;
            end else if (shift_byte != held_code) begin
              held_code <= shift_byte;
              if (shift_byte == 8'h5A) begin
                enter_pressed <= 1'b1;
              end else if (lookup[8]) begin
                ascii_out    <= lookup[7:0];
                letter_valid <= 1'b1;
              end
            end
          end
          C_BREAK: begin
            code_state <= C_NORMAL;
            if (shift_byte == held_code) held_code <= 8'h00;
          end
          C_EXT: begin
            code_state <= (shift_byte == 8'hF0) ? C_EXT_BREAK : C_NORMAL;
          end
          C_EXT_BREAK: code_state <= C_NORMAL;
          default:     code_state <= C_NORMAL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_letter_decoder.sv
// Testbench for ps2_letter_decoder: directed PS/2 frames with a queue-based
// scoreboard; a monitor pops the expected event whenever an output pulses.
module tb_ps2_letter_decoder;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b1;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic [7:0] ascii_out;
  logic       letter_valid;
  logic       enter_pressed;
  logic       frame_error;

  int errors = 0;
  int checks = 0;

  localparam int K_LETTER = 0;
  localparam int K_ENTER  = 1;
  localparam int K_ERR    = 2;

  typedef struct {
    int         kind;
    logic [7:0] ascii;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_kind;

  ps2_letter_decoder dut (
    .CLOCK_50      (CLOCK_50),
    .resetn        (resetn),
    .PS2_CLK       (PS2_CLK),
    .PS2_DAT       (PS2_DAT),
    .ascii_out     (ascii_out),
    .letter_valid  (letter_valid),
    .enter_pressed (enter_pressed),
    .frame_error   (frame_error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic expect_evt(input int kind, input logic [7:0] a);
    exp_t e;
    e.kind  = kind;
    e.ascii = a;
    exp_q.push_back(e);
  endtask

  // Monitor: every output pulse must match the next queued expectation.
  always @(negedge CLOCK_50) begin
    if (resetn && (letter_valid || enter_pressed || frame_error)) begin
      mon_kind = letter_valid ? K_LETTER : (enter_pressed ? K_ENTER : K_ERR);
      check("no_simultaneous", 32'(letter_valid & enter_pressed), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got kind %0d ascii %0h, want none", mon_kind, ascii_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", 32'(mon_kind), 32'(mon_e.kind));
        if (mon_e.kind == K_LETTER) check("ascii_out", 32'(ascii_out), 32'(mon_e.ascii));
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // One PS/2 bit: data set up, clock low 20 cycles, clock high again.
  task automatic ps2_bit(input logic b);
    PS2_DAT = b;
    wait_clk(10);
    PS2_CLK = 1'b0;
    wait_clk(20);
    PS2_CLK = 1'b1;
    wait_clk(10);
  endtask

  // Frame bits in wire order: [0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop.
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par,
                                           input logic bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) ps2_bit(f[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b0, 1'b0), 11);
    PS2_DAT = 1'b1;
    wait_clk(40);
  endtask

  logic [10:0] fr;

  initial begin
    // Reset state
    #3 resetn = 1'b0;
    #2;
    check("rst_ascii", 32'(ascii_out), 32'h00);
    check("rst_letter_valid", 32'(letter_valid), 32'd0);
    check("rst_enter", 32'(enter_pressed), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    wait_clk(5);
    resetn = 1'b1;
    wait_clk(20);

    // Single letter, then its break sequence
    expect_evt(K_LETTER, 8'h41);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("ascii_hold_A", 32'(ascii_out), 32'h41);

    // Typematic repeat and re-press
    expect_evt(K_LETTER, 8'h52);
    send_byte(8'h2D);
    send_byte(8'h2D);
    send_byte(8'h2D);
    send_byte(8'hF0);
    send_byte(8'h2D);
    expect_evt(K_LETTER, 8'h52);
    send_byte(8'h2D);

    // Enter, then keypad Enter (extended) produces nothing
    expect_evt(K_ENTER, 8'h00);
    send_byte(8'h5A);
    send_byte(8'hE0);
    send_byte(8'h5A);
    check("ascii_after_enter", 32'(ascii_out), 32'h52);

    // Parity error, then a good frame
    expect_evt(K_ERR, 8'h00);
    send_bits(mk_frame(8'h1C, 1'b1, 1'b0), 11);
    wait_clk(40);
    expect_evt(K_LETTER, 8'h42);
    send_byte(8'h32);

    // Bad start bit and bad stop bit
    expect_evt(K_ERR, 8'h00);
    ps2_bit(1'b1);
    wait_clk(40);
    expect_evt(K_ERR, 8'h00);
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11);
    PS2_DAT = 1'b1;
    wait_clk(40);

    // Timeout after start + 3 data bits
    expect_evt(K_ERR, 8'h00);
    send_bits(mk_frame(8'h1A, 1'b0, 1'b0), 4);
    PS2_DAT = 1'b1;
    wait_clk(50500);
    expect_evt(K_LETTER, 8'h5A);
    send_byte(8'h1A);
    check("ascii_hold_Z", 32'(ascii_out), 32'h5A);

    // Reset in the middle of data bit 4
    fr = mk_frame(8'h35, 1'b0, 1'b0);
    send_bits(fr, 5);
    PS2_DAT = fr[5];
    wait_clk(10);
    PS2_CLK = 1'b0;
    wait_clk(10);
    resetn = 1'b0;
    #1;
    check("midrst_ascii", 32'(ascii_out), 32'h00);
    check("midrst_letter_valid", 32'(letter_valid), 32'd0);
    check("midrst_enter", 32'(enter_pressed), 32'd0);
    check("midrst_frame_error", 32'(frame_error), 32'd0);
    wait_clk(10);
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    wait_clk(20);
    resetn = 1'b1;
    wait_clk(40);
    expect_evt(K_LETTER, 8'h59);
    send_byte(8'h35);

    wait_clk(100);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
